// File: rtl/snn_mem_pkg.sv
// Shared types and saturating arithmetic for the membrane-potential
// read-modify-write path.
package snn_mem_pkg;

   localparam int MEM_ADDR_W  = 11;
   localparam int MEM_DELTA_W = 8;

   typedef enum logic {
      OP_ACC = 1'b0,
      OP_CLR = 1'b1
   } mem_op_e;

   // Identifies the requester that was granted most recently.
   typedef enum logic {
      PTR_UPD   = 1'b0,
      PTR_FLUSH = 1'b1
   } rr_ptr_e;

   typedef struct packed {
      logic                   valid;
      mem_op_e                op;
      logic [MEM_ADDR_W-1:0]  addr;
      logic [MEM_DELTA_W-1:0] delta;
   } mem_req_t;

   // Operands arrive sign-extended to 64 bits; the result is clamped to a
   // signed range of the given width so the caller can truncate safely.
   function automatic logic signed [63:0] sat_add(
      input logic signed [63:0] a,
      input logic signed [63:0] b,
      input int                 width
   );
      logic signed [63:0] sum;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sum = a + b;
      hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (width - 1));
      if (sum > hi)
         return hi;
      else if (sum < lo)
         return lo;
      else
         return sum;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter between the accumulate and flush requesters.
// Grants are combinational; the pointer remembers the last winner.
module rr_arbiter2
   import snn_mem_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_upd,
   input  logic req_flush,
   output logic gnt_upd,
   output logic gnt_flush
);

   rr_ptr_e last_q;

   always_comb begin
      gnt_flush = !rst && req_flush && (!req_upd || (last_q == PTR_UPD));
      gnt_upd   = !rst && req_upd && (!req_flush || (last_q == PTR_FLUSH));
   end

   // Resetting to PTR_UPD lets flush win the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         last_q <= PTR_UPD;
      else if (gnt_upd || gnt_flush)
         last_q <= gnt_flush ? PTR_FLUSH : PTR_UPD;
   end

endmodule

// File: rtl/bram_rmw_scheduler.sv
// Pipelined read-modify-write scheduler for a dual-port BRAM of membrane
// potentials: read on port A, write on port B, hazards forwarded, no stalls.
module bram_rmw_scheduler
   import snn_mem_pkg::*;
#(
   parameter int DATA_WIDTH  = 36,
   parameter int ADDR_WIDTH  = 11,
   parameter int DELTA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [ADDR_WIDTH-1:0] upd_addr,
   input  logic [DELTA_WIDTH-1:0] upd_delta,
   input  logic                  flush_valid,
   output logic                  flush_ready,
   input  logic [ADDR_WIDTH-1:0] flush_addr,
   output logic                  flush_rvalid,
   output logic [ADDR_WIDTH-1:0] flush_raddr,
   output logic [DATA_WIDTH-1:0] flush_rdata,
   output logic                  bram_en_a,
   output logic                  bram_we_a,
   output logic [ADDR_WIDTH-1:0] bram_addr_a,
   output logic [DATA_WIDTH-1:0] bram_din_a,
   input  logic [DATA_WIDTH-1:0] bram_dout_a,
   output logic                  bram_en_b,
   output logic                  bram_we_b,
   output logic [ADDR_WIDTH-1:0] bram_addr_b,
   output logic [DATA_WIDTH-1:0] bram_din_b,
   output logic                  idle
);

   logic gnt_upd;
   logic gnt_flush;

   mem_req_t req_p0;
   mem_req_t req_p1;
   mem_req_t req_p2;

   logic                         fwd_hit_p2;
   logic signed [DATA_WIDTH-1:0] fwd_data_p2;
   logic signed [DATA_WIDTH-1:0] old_p2;
   logic signed [DATA_WIDTH-1:0] wdata_p2;

   rr_arbiter2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_upd   (upd_valid),
      .req_flush (flush_valid),
      .gnt_upd   (gnt_upd),
      .gnt_flush (gnt_flush)
   );

   assign upd_ready   = gnt_upd;
   assign flush_ready = gnt_flush;

   // S0: the granted request, in the common op format
   always_comb begin
      req_p0.valid = gnt_upd || gnt_flush;
      req_p0.op    = gnt_flush ? OP_CLR : OP_ACC;
      req_p0.addr  = gnt_flush ? MEM_ADDR_W'(flush_addr) : MEM_ADDR_W'(upd_addr);
      req_p0.delta = gnt_flush ? '0 : MEM_DELTA_W'(upd_delta);
   end

   // S2: merge the forwarded word over the stale BRAM read, then modify
   always_comb begin
      old_p2 = fwd_hit_p2 ? fwd_data_p2 : $signed(bram_dout_a);
      if (req_p2.op == OP_CLR)
         wdata_p2 = '0;
      else
         wdata_p2 = DATA_WIDTH'(sat_add(64'(old_p2), 64'($signed(req_p2.delta)), DATA_WIDTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_p1       <= '0;
         req_p2       <= '0;
         fwd_hit_p2   <= 1'b0;
         flush_rvalid <= 1'b0;
         flush_raddr  <= '0;
         flush_rdata  <= '0;
      end else begin
         req_p1       <= req_p0;
         req_p2       <= req_p1;
         // The S1 read on this edge sees the word before the S2 write lands.
         fwd_hit_p2   <= req_p1.valid && req_p2.valid && (req_p1.addr == req_p2.addr);
         flush_rvalid <= req_p2.valid && (req_p2.op == OP_CLR);
         if (req_p2.valid && (req_p2.op == OP_CLR)) begin
            flush_raddr <= ADDR_WIDTH'(req_p2.addr);
            flush_rdata <= old_p2;
         end
      end
   end

   always_ff @(posedge clk) begin
      fwd_data_p2 <= wdata_p2;
   end

   // S1: port A read issue
   assign bram_en_a   = req_p1.valid && !rst;
   assign bram_we_a   = 1'b0;
   assign bram_addr_a = ADDR_WIDTH'(req_p1.addr);
   assign bram_din_a  = '0;

   // S2: port B write-back, suppressed whenever reset is asserted
   assign bram_we_b   = req_p2.valid && !rst;
   assign bram_en_b   = bram_we_b;
   assign bram_addr_b = ADDR_WIDTH'(req_p2.addr);
   assign bram_din_b  = bram_we_b ? wdata_p2 : '0;

   assign idle = !(req_p1.valid || req_p2.valid || flush_rvalid);

endmodule

// File: tb/tb_bram_rmw_scheduler.sv
// Bench for bram_rmw_scheduler: a read-first BRAM model on the ports and a
// serial memory model that applies each accepted op in grant order.
module tb_bram_rmw_scheduler;

   localparam longint MAXV = 64'sd34359738367;
   localparam longint MINV = -64'sd34359738368;

   logic        clk = 1'b0;
   logic        rst;
   logic        upd_valid;
   logic        upd_ready;
   logic [10:0] upd_addr;
   logic [7:0]  upd_delta;
   logic        flush_valid;
   logic        flush_ready;
   logic [10:0] flush_addr;
   logic        flush_rvalid;
   logic [10:0] flush_raddr;
   logic [35:0] flush_rdata;
   logic        bram_en_a;
   logic        bram_we_a;
   logic [10:0] bram_addr_a;
   logic [35:0] bram_din_a;
   logic [35:0] bram_dout_a;
   logic        bram_en_b;
   logic        bram_we_b;
   logic [10:0] bram_addr_b;
   logic [35:0] bram_din_b;
   logic        idle;

   logic        pre_we;
   logic [10:0] pre_addr;
   logic [35:0] pre_data;
   logic [35:0] ram [0:2047];

   logic [35:0] ref_mem [0:2047];

   typedef struct {
      int          t;
      bit          fl;
      logic [10:0] a;
      logic [7:0]  d;
   } op_t;

   typedef struct {
      int          due;
      logic [10:0] a;
      logic [35:0] v;
   } fr_t;

   op_t pend[$];
   fr_t fq[$];

   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   bit          last_fl = 1'b0;
   logic [35:0] last_rdata = '0;

   bram_rmw_scheduler #(
      .DATA_WIDTH  (36),
      .ADDR_WIDTH  (11),
      .DELTA_WIDTH (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
      .upd_addr     (upd_addr),
      .upd_delta    (upd_delta),
      .flush_valid  (flush_valid),
      .flush_ready  (flush_ready),
      .flush_addr   (flush_addr),
      .flush_rvalid (flush_rvalid),
      .flush_raddr  (flush_raddr),
      .flush_rdata  (flush_rdata),
      .bram_en_a    (bram_en_a),
      .bram_we_a    (bram_we_a),
      .bram_addr_a  (bram_addr_a),
      .bram_din_a   (bram_din_a),
      .bram_dout_a  (bram_dout_a),
      .bram_en_b    (bram_en_b),
      .bram_we_b    (bram_we_b),
      .bram_addr_b  (bram_addr_b),
      .bram_din_b   (bram_din_b),
      .idle         (idle)
   );

   always #5 clk = ~clk;

   // Read-first dual-port RAM with a bench-side preload port.
   always @(posedge clk) begin
      if (bram_en_a)
         bram_dout_a <= ram[bram_addr_a];
      if (pre_we)
         ram[pre_addr] <= pre_data;
      else if (bram_we_b)
         ram[bram_addr_b] <= bram_din_b;
   end

   function automatic logic [35:0] sat36(input logic [35:0] a, input logic [7:0] d);
      longint s;
      s = longint'($signed(a)) + longint'($signed(d));
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
      return 36'(s);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, check this cycle's outputs
   // against the model, then advance the model's arbitration.
   task automatic cycle(input bit r, input bit uv, input logic [10:0] ua, input logic [7:0] ud,
                        input bit fv, input logic [10:0] fa, output bit gf);
      bit          eu;
      bit          ef;
      bit          idle_exp;
      logic [35:0] old;
      logic [35:0] nv;
      op_t         o;
      rst = r; upd_valid = uv; upd_addr = ua; upd_delta = ud;
      flush_valid = fv; flush_addr = fa;
      #1;
      gf = flush_ready;
      if (r) begin
         pend.delete();
         last_fl = 1'b0;
      end
      if (cyc > 0) begin
         chk("we_a", 64'(bram_we_a), 64'(0));
         chk("din_a", 64'(bram_din_a), 64'(0));
         if (pend.size() > 0 && pend[pend.size()-1].t == cyc - 1) begin
            chk("en_a", 64'(bram_en_a), 64'(1));
            chk("addr_a", 64'(bram_addr_a), 64'(pend[pend.size()-1].a));
         end else
            chk("en_a", 64'(bram_en_a), 64'(0));
         if (!r) begin
            idle_exp = (pend.size() == 0) && !(fq.size() > 0 && fq[0].due == cyc);
            chk("idle", 64'(idle), 64'(idle_exp));
         end
         if (pend.size() > 0 && pend[0].t == cyc - 2) begin
            o   = pend.pop_front();
            old = ref_mem[o.a];
            nv  = o.fl ? 36'd0 : sat36(old, o.d);
            ref_mem[o.a] = nv;
            if (o.fl) fq.push_back('{cyc + 1, o.a, old});
            chk("we_b", 64'(bram_we_b), 64'(1));
            chk("en_b", 64'(bram_en_b), 64'(1));
            chk("addr_b", 64'(bram_addr_b), 64'(o.a));
            chk("din_b", 64'(bram_din_b), 64'(nv));
         end else begin
            chk("we_b", 64'(bram_we_b), 64'(0));
            chk("en_b", 64'(bram_en_b), 64'(0));
         end
         if (fq.size() > 0 && fq[0].due == cyc) begin
            chk("rvalid", 64'(flush_rvalid), 64'(1));
            chk("raddr", 64'(flush_raddr), 64'(fq[0].a));
            chk("rdata", 64'(flush_rdata), 64'(fq[0].v));
            last_rdata = flush_rdata;
            void'(fq.pop_front());
         end else
            chk("rvalid", 64'(flush_rvalid), 64'(0));
      end
      eu = 1'b0;
      ef = 1'b0;
      if (!r) begin
         if (uv && fv) begin
            ef = !last_fl;
            eu = last_fl;
         end else begin
            eu = uv;
            ef = fv;
         end
      end
      if (cyc > 0) begin
         chk("upd_ready", 64'(upd_ready), 64'(eu));
         chk("flush_ready", 64'(flush_ready), 64'(ef));
      end
      if (eu || ef) begin
         pend.push_back('{cyc, ef, ef ? fa : ua, ef ? 8'd0 : ud});
         last_fl = ef;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic preload(input logic [10:0] a, input logic [35:0] v);
      bit g;
      pre_we = 1'b1; pre_addr = a; pre_data = v;
      ref_mem[a] = v;
      cycle(1'b1, 1'b1, 11'd0, 8'd0, 1'b1, 11'd0, g);
      pre_we = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      bit g;
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 11'd0, g);
   endtask

   initial begin
      bit          g;
      logic [5:0]  pat;
      rst = 1'b1; upd_valid = 1'b0; upd_addr = '0; upd_delta = '0;
      flush_valid = 1'b0; flush_addr = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      @(negedge clk);

      for (int i = 0; i < 32; i++)
         preload(11'(i), 36'($urandom_range(0, 200)));
      preload(11'd1, 36'd100);
      preload(11'd2, 36'h7_FFFF_FFFF);
      preload(11'd3, 36'h8_0000_0000);
      preload(11'd5, 36'd10);
      preload(11'd7, 36'd0);
      preload(11'd9, 36'd4);
      preload(11'd16, 36'h7_FFFF_FFC0);
      preload(11'd17, 36'h7_FFFF_FFF0);
      preload(11'd18, 36'h8_0000_0040);
      preload(11'd19, 36'h8_0000_0010);
      cycle(1'b1, 1'b0, 11'd0, 8'd0, 1'b0, 11'd0, g);

      // Reset state on the first cycle out of reset.
      cycle(1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 11'd0, g);
      chk("rst_idle", 64'(idle), 64'(1));
      chk("rst_raddr", 64'(flush_raddr), 64'(0));
      chk("rst_rdata", 64'(flush_rdata), 64'(0));
      chk("rst_addr_b", 64'(bram_addr_b), 64'(0));
      chk("rst_din_b", 64'(bram_din_b), 64'(0));

      // Single accumulate then flush of the same word.
      cycle(1'b0, 1'b1, 11'd5, 8'sd3, 1'b0, 11'd0, g);
      idle_cycles(3);
      chk("acc_mem5", 64'(ram[5]), 64'(13));
      cycle(1'b0, 1'b0, 11'd0, 8'd0, 1'b1, 11'd5, g);
      idle_cycles(4);
      chk("flush_rdata5", 64'(last_rdata), 64'(13));
      chk("flush_mem5", 64'(ram[5]), 64'(0));

      // Same-address burst exercises forwarding.
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 1'b1, 11'd7, 8'sd1, 1'b0, 11'd0, g);
      idle_cycles(4);
      chk("burst_mem7", 64'(ram[7]), 64'(4));

      // Saturation at both ends.
      cycle(1'b0, 1'b1, 11'd2, 8'sd5, 1'b0, 11'd0, g);
      cycle(1'b0, 1'b1, 11'd3, 8'hFF, 1'b0, 11'd0, g);
      idle_cycles(4);
      chk("sat_hi", 64'(ram[2]), 64'(36'h7_FFFF_FFFF));
      chk("sat_lo", 64'(ram[3]), 64'(36'h8_0000_0000));

      // Contention straight out of reset alternates starting with flush.
      cycle(1'b1, 1'b0, 11'd0, 8'd0, 1'b0, 11'd0, g);
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 11'd20, 8'sd1, 1'b1, 11'd21, g);
         pat = {pat[4:0], g};
      end
      idle_cycles(4);
      chk("rr_pattern", 64'(pat), 64'(6'b101010));

      // Accumulate, flush, accumulate on one address, back to back.
      cycle(1'b0, 1'b1, 11'd9, 8'sd2, 1'b0, 11'd0, g);
      cycle(1'b0, 1'b0, 11'd0, 8'd0, 1'b1, 11'd9, g);
      cycle(1'b0, 1'b1, 11'd9, 8'sd1, 1'b0, 11'd0, g);
      idle_cycles(4);
      chk("mix_rdata9", 64'(last_rdata), 64'(6));
      chk("mix_mem9", 64'(ram[9]), 64'(1));

      // Reset while an accumulate is in flight drops it.
      cycle(1'b0, 1'b1, 11'd1, 8'sd5, 1'b0, 11'd0, g);
      cycle(1'b1, 1'b0, 11'd0, 8'd0, 1'b0, 11'd0, g);
      cycle(1'b1, 1'b0, 11'd0, 8'd0, 1'b0, 11'd0, g);
      cycle(1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 11'd0, g);
      chk("rstmid_idle", 64'(idle), 64'(1));
      idle_cycles(2);
      chk("rstmid_mem1", 64'(ram[1]), 64'(100));

      // Random traffic over a small address window, including near-limit words.
      for (int i = 0; i < 400; i++)
         cycle(1'b0, 1'($urandom_range(0, 1)), 11'($urandom_range(12, 19)), 8'($urandom),
               1'($urandom_range(0, 3) == 0), 11'($urandom_range(12, 19)), g);
      idle_cycles(5);

      for (int i = 0; i < 32; i++)
         chk("final_mem", 64'(ram[i]), 64'(ref_mem[i]));
      chk("pend_empty", 64'(pend.size()), 64'(0));
      chk("fq_empty", 64'(fq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
